// File: rtl/car_control_pkg.sv
// Shared screen geometry, lane constants, FSM state type and the lane wrap helper.
package car_control_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned CAR_WIDTH = 40;

  localparam int unsigned CAR_Y1 = 60;
  localparam int unsigned CAR_Y2 = 110;
  localparam int unsigned CAR_Y3 = 160;
  localparam int unsigned CAR_Y4 = 210;
  localparam int unsigned CAR_Y5 = 260;
  localparam int unsigned CAR_Y6 = 310;
  localparam int unsigned CAR_Y7 = 360;
  localparam int unsigned CAR_Y8 = 410;

  localparam logic [9:0] CAR_X0_1 = 10'd638;
  localparam logic [9:0] CAR_X0_2 = 10'd1;
  localparam logic [9:0] CAR_X0_3 = 10'd100;
  localparam logic [9:0] CAR_X0_4 = 10'd200;
  localparam logic [9:0] CAR_X0_5 = 10'd300;
  localparam logic [9:0] CAR_X0_6 = 10'd400;
  localparam logic [9:0] CAR_X0_7 = 10'd500;
  localparam logic [9:0] CAR_X0_8 = 10'd600;

  localparam logic [2:0] LANE_STEP_1 = 3'd3;
  localparam logic [2:0] LANE_STEP_2 = 3'd2;
  localparam logic [2:0] LANE_STEP_3 = 3'd1;
  localparam logic [2:0] LANE_STEP_4 = 3'd4;
  localparam logic [2:0] LANE_STEP_5 = 3'd3;
  localparam logic [2:0] LANE_STEP_6 = 3'd2;
  localparam logic [2:0] LANE_STEP_7 = 3'd4;
  localparam logic [2:0] LANE_STEP_8 = 3'd1;

  // Bit i set means lane i+1 moves rightward.
  localparam logic [7:0] LANE_DIR_MASK = 8'b01010101;

  localparam logic [7:0][9:0] CAR_X0 = {CAR_X0_8, CAR_X0_7, CAR_X0_6, CAR_X0_5,
                                        CAR_X0_4, CAR_X0_3, CAR_X0_2, CAR_X0_1};
  localparam logic [7:0][2:0] LANE_STEP = {LANE_STEP_8, LANE_STEP_7, LANE_STEP_6, LANE_STEP_5,
                                           LANE_STEP_4, LANE_STEP_3, LANE_STEP_2, LANE_STEP_1};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [9:0] next_x(input logic [9:0] x, input logic [2:0] step,
                                        input logic right);
    logic [10:0] sum;
    logic [10:0] hd;
    hd = 11'(H_DISPLAY);
    if (right) begin
      sum = {1'b0, x} + {8'd0, step};
      if (sum >= hd) sum = sum - hd;
    end else if (x < {7'd0, step}) begin
      sum = {1'b0, x} + hd - {8'd0, step};
    end else begin
      sum = {1'b0, x} - {8'd0, step};
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/car_control_lane.sv
// One lane: a single position register with screen wrap, reload beats move.
module car_lane
  import car_control_pkg::*;
#(
  parameter logic [9:0] X0    = '0,
  parameter logic [2:0] STEP  = 3'd1,
  parameter logic       RIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       load,
  input  logic       move,
  output logic [9:0] x
);

  always_ff @(posedge clk) begin
    if (load) begin
      x <= X0;
    end else if (move) begin
      x <= next_x(x, STEP, RIGHT);
    end
  end

endmodule

// File: rtl/car_control.sv
// Move-tick timer, speed-decrease reload and LOAD/RUN/HOLD control for eight car lanes.
module car_control
  import car_control_pkg::*;
#(
  parameter int unsigned PERIOD_BASE = 250000,
  parameter int unsigned PERIOD_STEP = 10000,
  parameter int unsigned PERIOD_MIN  = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] speed_car,
  input  logic       freeze,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [9:0] car_x5,
  output logic [9:0] car_x6,
  output logic [9:0] car_x7,
  output logic [9:0] car_x8,
  output logic       tick
);

  localparam logic [23:0] BASE24 = 24'(PERIOD_BASE);
  localparam logic [23:0] STEP24 = 24'(PERIOD_STEP);
  localparam logic [23:0] MIN24  = 24'(PERIOD_MIN);

  state_t      state;
  logic [23:0] cnt;
  logic [4:0]  prev_speed;
  logic [23:0] reduction;
  logic [23:0] period;
  logic        wrap;
  logic        dec;
  logic        load;
  logic        move;
  logic [9:0]  lane_x [8];

  // Clamp before subtracting so the period never underflows below the floor.
  always_comb begin
    reduction = {19'd0, speed_car} * STEP24;
    if (reduction >= BASE24 - MIN24) period = MIN24;
    else                             period = BASE24 - reduction;
  end

  assign wrap = (cnt >= period - 24'd1);
  assign dec  = (speed_car < prev_speed);
  assign load = RST | dec | (state == ST_LOAD);
  assign move = tick & ~freeze & ~dec & ~RST & (state == ST_RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      tick       <= 1'b0;
      prev_speed <= '0;
    end else begin
      prev_speed <= speed_car;
      tick       <= 1'b0;
      if (dec) begin
        state <= ST_LOAD;
        cnt   <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            cnt   <= '0;
            state <= freeze ? ST_HOLD : ST_RUN;
          end
          ST_RUN: begin
            if (freeze) begin
              state <= ST_HOLD;
            end else if (wrap) begin
              cnt  <= '0;
              tick <= 1'b1;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          ST_HOLD: begin
            if (!freeze) begin
              state <= ST_RUN;
              if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
              end else begin
                cnt <= cnt + 24'd1;
              end
            end
          end
          default: begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    car_lane #(
      .X0   (CAR_X0[i]),
      .STEP (LANE_STEP[i]),
      .RIGHT(LANE_DIR_MASK[i])
    ) u_lane (
      .clk (CLK),
      .load(load),
      .move(move),
      .x   (lane_x[i])
    );
  end

  assign car_x1 = lane_x[0];
  assign car_x2 = lane_x[1];
  assign car_x3 = lane_x[2];
  assign car_x4 = lane_x[3];
  assign car_x5 = lane_x[4];
  assign car_x6 = lane_x[5];
  assign car_x7 = lane_x[6];
  assign car_x8 = lane_x[7];

endmodule

// File: tb/tb_car_control.sv
// Directed bench for car_control with shortened tick periods (250/10/50 cycles).
module tb_car_control;

  localparam int unsigned PB = 250;
  localparam int unsigned PS = 10;
  localparam int unsigned PM = 50;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] speed_car;
  logic       freeze;
  logic [9:0] cx [8];
  logic       tick;

  int tests = 0;
  int fails = 0;

  int x0    [8] = '{638, 1, 100, 200, 300, 400, 500, 600};
  int stp   [8] = '{3, 2, 1, 4, 3, 2, 4, 1};
  int right [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int pos   [8];

  typedef struct {
    int speed;
    int period;
  } vec_t;
  vec_t vecs [6];

  car_control #(
    .PERIOD_BASE(PB),
    .PERIOD_STEP(PS),
    .PERIOD_MIN (PM)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .speed_car(speed_car),
    .freeze   (freeze),
    .car_x1   (cx[0]),
    .car_x2   (cx[1]),
    .car_x3   (cx[2]),
    .car_x4   (cx[3]),
    .car_x5   (cx[4]),
    .car_x6   (cx[5]),
    .car_x7   (cx[6]),
    .car_x8   (cx[7]),
    .tick     (tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic model_reload();
    for (int i = 0; i < 8; i++) pos[i] = x0[i];
  endtask

  task automatic model_move();
    for (int i = 0; i < 8; i++)
      pos[i] = right[i] != 0 ? (pos[i] + stp[i]) % 640 : (pos[i] + 640 - stp[i]) % 640;
  endtask

  task automatic check_lanes(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_x%0d", tag, i + 1), int'(cx[i]), pos[i]);
  endtask

  // Counts edges until tick is seen high; an expired bound is a failure.
  task automatic wait_tick(input string name, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n < 2000);
    if (!tick) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no tick expected tick within 2000 cycles", name);
    end
  endtask

  // Waits for a tick, optionally checks its latency, then checks the move one edge later.
  task automatic tick_and_check(input string name, input bit check_n, input int exp_n);
    int n;
    wait_tick(name, n);
    if (check_n) check({name, "_latency"}, n, exp_n);
    step(1);
    model_move();
    check_lanes(name);
  endtask

  initial begin
    int seen;
    vecs[0] = '{speed: 0,  period: 250};
    vecs[1] = '{speed: 5,  period: 200};
    vecs[2] = '{speed: 19, period: 60};
    vecs[3] = '{speed: 20, period: 50};
    vecs[4] = '{speed: 25, period: 50};
    vecs[5] = '{speed: 31, period: 50};

    RST = 1'b1;
    speed_car = 5'd0;
    freeze = 1'b0;
    step(2);
    model_reload();
    check_lanes("reset");
    check("reset_tick", int'(tick), 0);

    // First tick lands period cycles after LOAD exits; lanes 1/2 wrap.
    RST = 1'b0;
    tick_and_check("first_tick", 1'b1, PB + 1);
    check("wrap_right_x1", int'(cx[0]), 1);
    check("wrap_left_x2", int'(cx[1]), 639);

    for (int v = 0; v < 6; v++) begin
      speed_car = 5'(vecs[v].speed);
      tick_and_check($sformatf("sync_s%0d", vecs[v].speed), 1'b0, 0);
      tick_and_check($sformatf("period_s%0d", vecs[v].speed), 1'b1, vecs[v].period - 1);
    end

    // Freeze across three periods: counter held at 11, resumes from there.
    step(10);
    freeze = 1'b1;
    seen = 0;
    for (int k = 0; k < 3 * PM; k++) begin
      step(1);
      if (tick) seen = 1;
    end
    check("freeze_no_tick", seen, 0);
    check_lanes("freeze_hold");
    freeze = 1'b0;
    tick_and_check("freeze_resume", 1'b1, PM - 11);

    // Plain speed decrease reloads every lane.
    speed_car = 5'd7;
    step(1);
    model_reload();
    check_lanes("dec_reload");
    begin
      int n;
      wait_tick("s7_tick", n);
      check("s7_first_latency", n, (PB - 7 * PS) + 1);
    end
    speed_car = 5'd0;
    step(1);
    model_reload();
    check_lanes("dec_on_tick");
    check("dec_on_tick_tick", int'(tick), 0);
    tick_and_check("after_dec", 1'b1, PB + 1);

    // Reset while frozen: reload, stay held, then count a full period.
    freeze = 1'b1;
    RST = 1'b1;
    step(1);
    model_reload();
    check_lanes("rst_frozen");
    RST = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (tick) seen = 1;
    end
    check("rst_hold_no_tick", seen, 0);
    check_lanes("rst_hold");
    freeze = 1'b0;
    tick_and_check("rst_resume", 1'b1, PB);

    // Counter already past the new, shorter period wraps on the next cycle.
    step(100);
    speed_car = 5'd25;
    tick_and_check("overrun_wrap", 1'b1, 1);
    tick_and_check("overrun_next", 1'b1, PM - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule

// File: doc/car_control.md
CAR_CONTROL -- requirements
Module: car_control

Interface
REQ-001 SHALL: the block has one clock, CLK; reset is RST, synchronous and active-high.
REQ-002 SHALL: parameter PERIOD_BASE, default 250000, move-tick period in CLK cycles at speed_car = 0.
REQ-003 SHALL: parameter PERIOD_STEP, default 10000, period reduction per speed_car unit.
REQ-004 SHALL: parameter PERIOD_MIN, default 50000, floor of the move-tick period.
REQ-005 SHALL: port CLK  input  1  system clock.
REQ-006 SHALL: port RST  input  1  synchronous active-high reset.
REQ-007 SHALL: port speed_car  input  5  level speed index from the player controller.
REQ-008 SHALL: port freeze  input  1  high holds every car in place.
REQ-009 SHALL: port car_x1..car_x8  output  10 each  car left-edge x position, lanes 1..8.
REQ-010 SHALL: port tick  output  1  one-cycle pulse on each move tick.

Function
REQ-011 SHALL: a 24-bit tick counter counts CLK cycles up to period-1, then wraps to 0 and asserts tick for that one cycle.
REQ-012 SHALL: period = max(PERIOD_MIN, PERIOD_BASE - speed_car*PERIOD_STEP), computed in 24 bits without underflow; speed_car >= 20 gives PERIOD_MIN.
REQ-013 SHALL: if the counter is >= the new period after speed_car changes, the counter wraps on the next cycle; no cycle is lost and no overflow occurs.
REQ-014 SHALL: on a tick with freeze low, each lane i moves by LANE_STEP_i pixels; car_x outputs are registered and change on the cycle after tick is high.
REQ-015 SHALL: odd lanes move right: next = x + step, and if next >= H_DISPLAY then next = next - H_DISPLAY.
REQ-016 SHALL: even lanes move left: if x < step then next = x + H_DISPLAY - step, else next = x - step.
REQ-017 SHALL: all car_x values stay within 0..H_DISPLAY-1 at all times.
REQ-018 SHALL: while freeze is high, the tick counter holds, tick stays 0, and positions hold.
REQ-019 SHALL: when speed_car decreases from the value registered on the previous cycle (game over or manual reset), every lane reloads CAR_X0_i on the next cycle and the tick counter clears.
REQ-020 SHALL: when a speed decrease and a tick occur in the same cycle, the reload wins.
REQ-021 SHALL: freeze is ignored for the reload rule in REQ-019.
REQ-022 SHALL: the control FSM has three states. LOAD: one cycle after RST or a speed decrease; loads CAR_X0_i, then goes to RUN. RUN: moves cars on each tick; goes to HOLD when freeze is high. HOLD: no moves; returns to RUN when freeze is low.

Reset
REQ-023 SHALL: while RST is high, car_xi = CAR_X0_i, tick = 0, counter = 0, the registered previous speed = 0, and the FSM is in LOAD.
REQ-024 SHALL: RST asserted mid-tick or mid-move aborts the move; positions return to CAR_X0_i on the next edge.
REQ-025 SHALL: the first tick after reset release occurs exactly period cycles after LOAD exits.

Structure
REQ-026 SHALL: constants.v holds H_DISPLAY, CAR_WIDTH, CAR_Y1..8 (existing), plus the new CAR_X0_1..8, LANE_STEP_1..8 (1..4 pixels), and LANE_DIR_MASK = 8'b01010101, where 1 means rightward.
REQ-027 SHALL: one sub-module, car_lane, is instantiated 8 times; it holds one position register, the wrap arithmetic, and parameters for step, direction, and initial x.
REQ-028 SHALL: the tick counter, period computation, speed-decrease detect, and FSM live in car_control.

Verification
REQ-029 SHALL: RST for 2 cycles, then speed_car = 0 -> car_x1 = CAR_X0_1 until the first tick at cycle 250000 after LOAD, then car_x1 = CAR_X0_1 + LANE_STEP_1.
REQ-030 SHALL: speed_car = 5 -> ticks spaced 200000 cycles; speed_car = 25 -> ticks spaced 50000 cycles (floor).
REQ-031 SHALL: lane 1 preset to 638 with step 3 -> after one tick car_x1 = 1; lane 2 at 1 with step 2 -> car_x2 = 639.
REQ-032 SHALL: freeze high across 3 tick periods -> no tick pulses and positions unchanged; freeze low -> the count resumes from its held value.
REQ-033 SHALL: speed_car 7 -> 0 in the same cycle as a tick -> all lanes equal CAR_X0_i next cycle and no move is applied.
REQ-034 SHALL: RST pulse mid-run with freeze high -> positions reset to CAR_X0_i and the FSM passes through LOAD into HOLD.
